// File: rtl/gcode_command_sequencer.sv
// Purpose: queues parsed G-code commands and issues them one at a time to the execution unit.
// Latency: a command pushed into an empty queue raises exec_start one clock after it is accepted.
// Backpressure: cmd_ready = ~full; a pop frees space only after the edge, so ready stays low in the pop cycle.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   cmd_valid/cmd_ready, cmd_*       command intake from the parser (type + five signed operands)
//   pause, abort, clear_halt         level hold-off, flush/cancel pulse, halt-clear pulse
//   exec_start, exec_*               registered start and operands to the execution unit
//   exec_finish, exec_error          completion handshake from the execution unit
//   busy, halted, timeout_flag       status
//   done_count, err_count            wrapping completion/failure counters
//   last_err_type                    command code of the most recent failure
module gcode_command_sequencer #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 0,
    parameter bit STOP_ON_ERROR  = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [31:0]        cmd_type,
    input  logic signed [31:0] cmd_x,
    input  logic signed [31:0] cmd_y,
    input  logic signed [31:0] cmd_z,
    input  logic signed [31:0] cmd_e0,
    input  logic signed [31:0] cmd_e1,
    input  logic               pause,
    input  logic               abort,
    input  logic               clear_halt,
    output logic               exec_start,
    output logic [31:0]        exec_type,
    output logic signed [31:0] exec_x,
    output logic signed [31:0] exec_y,
    output logic signed [31:0] exec_z,
    output logic signed [31:0] exec_e0,
    output logic signed [31:0] exec_e1,
    input  logic               exec_finish,
    input  logic               exec_error,
    output logic               busy,
    output logic               halted,
    output logic               timeout_flag,
    output logic [15:0]        done_count,
    output logic [15:0]        err_count,
    output logic [31:0]        last_err_type
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef struct packed {
        logic [31:0]        typ;
        logic signed [31:0] x;
        logic signed [31:0] y;
        logic signed [31:0] z;
        logic signed [31:0] e0;
        logic signed [31:0] e1;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t        state;
    cmd_t          mem [DEPTH];
    cmd_t          wr_dat;
    cmd_t          head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   tmo_cnt;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          tmo_hit;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = ~full;
    assign busy      = (state != IDLE) | ~empty;

    // abort discards a coincident push and suppresses any pop in the same cycle
    assign push = cmd_valid & ~full & ~abort;
    assign pop  = (state == IDLE) & ~empty & ~pause & ~halted & ~abort;

    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);

    assign wr_dat = '{typ: cmd_type, x: cmd_x, y: cmd_y, z: cmd_z, e0: cmd_e0, e1: cmd_e1};
    assign head   = mem[rd_ptr];

    // Storage needs no reset: entries are only read once count says they were written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            exec_start    <= 1'b0;
            exec_type     <= '0;
            exec_x        <= '0;
            exec_y        <= '0;
            exec_z        <= '0;
            exec_e0       <= '0;
            exec_e1       <= '0;
            halted        <= 1'b0;
            timeout_flag  <= 1'b0;
            done_count    <= '0;
            err_count     <= '0;
            last_err_type <= '0;
            tmo_cnt       <= '0;
        end else begin
            // Applied first so that a halt set later in this block overrides it.
            if (clear_halt) begin
                halted       <= 1'b0;
                timeout_flag <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        exec_type  <= head.typ;
                        exec_x     <= head.x;
                        exec_y     <= head.y;
                        exec_z     <= head.z;
                        exec_e0    <= head.e0;
                        exec_e1    <= head.e1;
                        tmo_cnt    <= '0;
                        exec_start <= 1'b1;
                        state      <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (abort) begin
                        exec_start <= 1'b0;
                        state      <= RELEASE;
                    end else if (exec_finish) begin
                        if (exec_error) begin
                            err_count     <= err_count + 16'd1;
                            last_err_type <= exec_type;
                            if (STOP_ON_ERROR) begin
                                halted <= 1'b1;
                            end
                        end else begin
                            done_count <= done_count + 16'd1;
                        end
                        exec_start <= 1'b0;
                        state      <= RELEASE;
                    end else if (tmo_hit) begin
                        err_count     <= err_count + 16'd1;
                        last_err_type <= exec_type;
                        halted        <= 1'b1;
                        timeout_flag  <= 1'b1;
                        exec_start    <= 1'b0;
                        state         <= RELEASE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end

                RELEASE: begin
                    // Execution unit holds finish high through its post-command hold-off.
                    if (!exec_finish) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    exec_start <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcode_command_sequencer.sv
// Purpose: self-checking bench for gcode_command_sequencer with a scoreboard of expected issues.
// Latency: execution-unit model raises finish a programmable number of cycles after start.
// Backpressure: pushes hold cmd_valid until cmd_ready is seen, bounded by a cycle budget.
module tb_gcode_command_sequencer;

    localparam int DEPTH = 4;
    localparam int TMO   = 20;

    typedef struct packed {
        logic [31:0] t;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic [31:0] e0;
        logic [31:0] e1;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [31:0]        cmd_type = '0;
    logic signed [31:0] cmd_x = '0;
    logic signed [31:0] cmd_y = '0;
    logic signed [31:0] cmd_z = '0;
    logic signed [31:0] cmd_e0 = '0;
    logic signed [31:0] cmd_e1 = '0;
    logic               pause = 1'b0;
    logic               abort = 1'b0;
    logic               clear_halt = 1'b0;
    logic               exec_start;
    logic [31:0]        exec_type;
    logic signed [31:0] exec_x;
    logic signed [31:0] exec_y;
    logic signed [31:0] exec_z;
    logic signed [31:0] exec_e0;
    logic signed [31:0] exec_e1;
    logic               exec_finish = 1'b0;
    logic               exec_error = 1'b0;
    logic               busy;
    logic               halted;
    logic               timeout_flag;
    logic [15:0]        done_count;
    logic [15:0]        err_count;
    logic [31:0]        last_err_type;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_issued = 0;
    int   fin_delay = 5;
    bit   never_finish = 1'b0;
    int   mcnt = 0;
    logic start_q = 1'b0;

    gcode_command_sequencer #(
        .DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TMO),
        .STOP_ON_ERROR(1'b1)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_z(cmd_z), .cmd_e0(cmd_e0), .cmd_e1(cmd_e1),
        .pause(pause), .abort(abort), .clear_halt(clear_halt),
        .exec_start(exec_start), .exec_type(exec_type),
        .exec_x(exec_x), .exec_y(exec_y), .exec_z(exec_z), .exec_e0(exec_e0), .exec_e1(exec_e1),
        .exec_finish(exec_finish), .exec_error(exec_error),
        .busy(busy), .halted(halted), .timeout_flag(timeout_flag),
        .done_count(done_count), .err_count(err_count), .last_err_type(last_err_type)
    );

    initial forever #5 clk = ~clk;

    // Execution unit: finish pulses fin_delay cycles after start is seen; type 0x3FF fails.
    initial forever begin
        @(posedge clk);
        #1;
        if (reset) begin
            exec_finish = 1'b0; exec_error = 1'b0; mcnt = 0;
        end else if (exec_finish) begin
            exec_finish = 1'b0; exec_error = 1'b0; mcnt = 0;
        end else if (!exec_start) begin
            mcnt = 0;
        end else if (!never_finish) begin
            mcnt++;
            if (mcnt == fin_delay) begin
                exec_finish = 1'b1;
                exec_error  = (exec_type == 32'h3FF);
            end
        end
    end

    // Scoreboard: each rising exec_start must present the oldest expected command.
    initial forever begin
        exp_t got;
        exp_t e;
        @(negedge clk);
        if (exec_start && !start_q) begin
            n_issued++;
            n_checks++;
            got = {exec_type, exec_x, exec_y, exec_z, exec_e0, exec_e1};
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL issue_unexpected: got type %h, expected no issue", exec_type);
            end else begin
                e = sb.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL issue_operands: got %h, expected %h", got, e);
                end
            end
        end
        start_q = exec_start;
    end

    initial begin
        #400000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; cmd_valid = 1'b0; pause = 1'b0; abort = 1'b0; clear_halt = 1'b0;
        never_finish = 1'b0; fin_delay = 5;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic push_cmd(input logic [31:0] t, input int x, input int y, input int z,
                            input int e0, input int e1);
        exp_t e;
        bit   acc;
        acc = 1'b0;
        e = {t, x, y, z, e0, e1};
        sb.push_back(e);
        cmd_valid = 1'b1; cmd_type = t;
        cmd_x = x; cmd_y = y; cmd_z = z; cmd_e0 = e0; cmd_e1 = e1;
        for (int i = 0; i < 200 && !acc; i++) begin
            acc = cmd_ready;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL push_accept: type %h not accepted, expected acceptance", t);
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = !busy;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_idle: busy=%b, expected 0 within budget", name, busy);
        end
    endtask

    task automatic wait_start_rise(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = exec_start;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_start: exec_start=%b, expected 1 within budget", name, exec_start);
        end
    endtask

    task automatic count_high(output int hi);
        hi = 0;
        while (exec_start === 1'b1 && hi < 100) begin
            hi++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [191:0] ops;
        apply_reset();
        ops = {exec_type, exec_x, exec_y, exec_z, exec_e0, exec_e1};
        n_checks++; if (exec_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b, expected 0", exec_start); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, expected 1", cmd_ready); end
        n_checks++; if (ops !== 192'd0) begin n_fail++; $display("FAIL reset_operands: got %h, expected 0", ops); end
        n_checks++;
        if ({busy, halted, timeout_flag, done_count, err_count, last_err_type} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_status: busy=%b halted=%b tmo=%b done=%0d err=%0d last=%h, expected all 0",
                     busy, halted, timeout_flag, done_count, err_count, last_err_type);
        end
    endtask

    task automatic test_single();
        int hi;
        apply_reset();
        push_cmd(32'd1, 100, -50, 0, 0, 0);
        n_checks++; if (exec_start !== 1'b0) begin n_fail++; $display("FAIL single_early: exec_start=%b, expected 0", exec_start); end
        @(negedge clk);
        n_checks++; if (exec_start !== 1'b1) begin n_fail++; $display("FAIL single_latency: exec_start=%b, expected 1", exec_start); end
        count_high(hi);
        n_checks++; if (hi != 5) begin n_fail++; $display("FAIL single_start_width: got %0d cycles, expected 5", hi); end
        n_checks++; if (done_count !== 16'd1) begin n_fail++; $display("FAIL single_done: got %0d, expected 1", done_count); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_release_busy: got %b, expected 1", busy); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_clear: got %b, expected 0", busy); end
    endtask

    task automatic test_fill_drain();
        int base;
        apply_reset();
        base = n_issued;
        pause = 1'b1;
        for (int i = 0; i < 4; i++) push_cmd(32'd10 + 32'(i), i * 7, -i, i, 0, 1000 + i);
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_ready: got %b, expected 0", cmd_ready); end
        repeat (2) @(negedge clk);
        n_checks++; if (exec_start !== 1'b0) begin n_fail++; $display("FAIL fill_paused_start: got %b, expected 0", exec_start); end
        pause = 1'b0;
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL fill_pop_cycle_ready: got %b, expected 0", cmd_ready); end
        push_cmd(32'd14, -77, 88, -99, 5, 6);
        wait_idle("fill");
        n_checks++; if (done_count !== 16'd5) begin n_fail++; $display("FAIL fill_done: got %0d, expected 5", done_count); end
        n_checks++; if (n_issued - base != 5) begin n_fail++; $display("FAIL fill_issues: got %0d, expected 5", n_issued - base); end
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL fill_sb_left: got %0d, expected 0", sb.size()); end
    endtask

    task automatic test_error_halt();
        bit ok;
        apply_reset();
        push_cmd(32'd1, 1, 2, 3, 4, 5);
        push_cmd(32'h3FF, -1, -2, -3, -4, -5);
        push_cmd(32'd2, 7, 8, 9, 10, 11);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk); ok = halted; end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL err_halted: got %b, expected 1", halted); end
        repeat (10) @(negedge clk);
        n_checks++; if (err_count !== 16'd1) begin n_fail++; $display("FAIL err_count: got %0d, expected 1", err_count); end
        n_checks++; if (last_err_type !== 32'h3FF) begin n_fail++; $display("FAIL err_last_type: got %h, expected 3ff", last_err_type); end
        n_checks++; if (sb.size() != 1 || exec_start !== 1'b0) begin n_fail++; $display("FAIL err_blocked: pending=%0d start=%b, expected 1 and 0", sb.size(), exec_start); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL err_busy: got %b, expected 1", busy); end
        clear_halt = 1'b1;
        @(negedge clk);
        clear_halt = 1'b0;
        wait_idle("err");
        n_checks++; if (done_count !== 16'd2) begin n_fail++; $display("FAIL err_done: got %0d, expected 2", done_count); end
        n_checks++; if (halted !== 1'b0 || sb.size() != 0) begin n_fail++; $display("FAIL err_resume: halted=%b pending=%0d, expected 0 and 0", halted, sb.size()); end
    endtask

    task automatic test_timeout();
        int hi;
        apply_reset();
        never_finish = 1'b1;
        push_cmd(32'h55, 1, 2, 3, 4, 5);
        wait_start_rise("tmo");
        count_high(hi);
        n_checks++; if (hi != TMO) begin n_fail++; $display("FAIL tmo_width: got %0d cycles, expected %0d", hi, TMO); end
        n_checks++; if (timeout_flag !== 1'b1 || halted !== 1'b1) begin n_fail++; $display("FAIL tmo_flags: tmo=%b halted=%b, expected 1 1", timeout_flag, halted); end
        n_checks++; if (err_count !== 16'd1 || done_count !== 16'd0) begin n_fail++; $display("FAIL tmo_counts: err=%0d done=%0d, expected 1 0", err_count, done_count); end
        n_checks++; if (last_err_type !== 32'h55) begin n_fail++; $display("FAIL tmo_last_type: got %h, expected 55", last_err_type); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy: got %b, expected 0", busy); end
        clear_halt = 1'b1;
        @(negedge clk);
        clear_halt = 1'b0;
        n_checks++; if (timeout_flag !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: tmo=%b halted=%b, expected 0 0", timeout_flag, halted); end
        never_finish = 1'b0;
    endtask

    task automatic test_abort();
        int base;
        apply_reset();
        pause = 1'b1;
        for (int i = 0; i < 4; i++) push_cmd(32'd20 + 32'(i), i, i, i, i, i);
        pause = 1'b0;
        wait_start_rise("abort");
        base = n_issued;
        @(negedge clk);
        abort = 1'b1;
        cmd_valid = 1'b1; cmd_type = 32'h77;
        @(negedge clk);
        abort = 1'b0;
        cmd_valid = 1'b0;
        sb.delete();
        n_checks++; if (exec_start !== 1'b0) begin n_fail++; $display("FAIL abort_start: got %b, expected 0", exec_start); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b, expected 1", cmd_ready); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_flush: busy=%b, expected 0", busy); end
        repeat (20) @(negedge clk);
        n_checks++; if (n_issued != base) begin n_fail++; $display("FAIL abort_no_issue: got %0d issues, expected %0d", n_issued, base); end
        n_checks++; if (done_count !== 16'd0 || err_count !== 16'd0) begin n_fail++; $display("FAIL abort_counts: done=%0d err=%0d, expected 0 0", done_count, err_count); end
    endtask

    task automatic test_reset_mid_issue();
        logic [191:0] ops;
        apply_reset();
        push_cmd(32'd9, 11, -22, 33, -44, 55);
        push_cmd(32'd8, 1, 1, 1, 1, 1);
        wait_start_rise("rst");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        ops = {exec_type, exec_x, exec_y, exec_z, exec_e0, exec_e1};
        n_checks++; if (exec_start !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ctrl: start=%b ready=%b, expected 0 1", exec_start, cmd_ready); end
        n_checks++; if (ops !== 192'd0) begin n_fail++; $display("FAIL rst_mid_operands: got %h, expected 0", ops); end
        n_checks++; if (busy !== 1'b0 || halted !== 1'b0 || done_count !== 16'd0) begin n_fail++; $display("FAIL rst_mid_status: busy=%b halted=%b done=%0d, expected 0", busy, halted, done_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_error_halt();
        test_timeout();
        test_abort();
        test_reset_mid_issue();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
